// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: position counters, sync/valid decode with
// programmable polarity, optional en-gated output delay, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int DELAY    = 0,
  parameter int FW       = 16
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic [CW-1:0] x_raw,
  output logic [CW-1:0] y_raw,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (CW < 1 || FW < 1 || H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_err_width
    $error("vga_timing_gen: all widths must be >= 1");
  end
  if (64'(H_TOTAL) > (64'd1 << CW) || 64'(V_TOTAL) > (64'd1 << CW)) begin : g_err_fit
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (DELAY < 0 || DELAY > 15) begin : g_err_delay
    $error("vga_timing_gen: DELAY must be in 0..15");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic          HP       = (H_POL != 0);
  localparam logic          VP       = (V_POL != 0);
  // Packed as {valid, hsync, vsync}
  localparam logic [2:0]    BLANK    = {1'b0, ~HP, ~VP};

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          line_start_q, frame_start_q;
  logic          x_last, y_last;
  logic          act, hs_act, vs_act;
  logic [2:0]    dec;

  always_comb begin
    x_last  = (x_q == H_LAST);
    y_last  = (y_q == V_LAST);
    x_d     = x_last ? '0 : x_q + 1'b1;
    y_d     = y_q;
    frame_d = frame_q;
    if (x_last) begin
      y_d = y_last ? '0 : y_q + 1'b1;
      if (y_last) frame_d = frame_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // Strobes are computed every pclk so they drop after one cycle even when en stays low
      line_start_q  <= en & x_last;
      frame_start_q <= en & x_last & y_last;
      if (en) begin
        x_q     <= x_d;
        y_q     <= y_d;
        frame_q <= frame_d;
      end
    end
  end

  always_comb begin
    act    = (x_q < H_ACT_C) && (y_q < V_ACT_C);
    hs_act = (x_q >= HS_BEG) && (x_q < HS_END);
    vs_act = (y_q >= VS_BEG) && (y_q < VS_END);
    dec    = {act, (hs_act ? HP : ~HP), (vs_act ? VP : ~VP)};
  end

  if (DELAY == 0) begin : g_nodly
    assign {valid, hsync, vsync} = dec;
  end else begin : g_dly
    logic [2:0] dly_q [DELAY];

    always_ff @(posedge pclk) begin
      if (reset) begin
        for (int unsigned i = 0; i < DELAY; i++) dly_q[i] <= BLANK;
      end else if (en) begin
        dly_q[0] <= dec;
        for (int unsigned i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign {valid, hsync, vsync} = dly_q[DELAY-1];
  end

  assign h_cnt       = act ? x_q : '0;
  assign v_cnt       = act ? y_q : '0;
  assign x_raw       = x_q;
  assign y_raw       = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: default VGA line timing, a small
// 12x7 mode (plain, 1-of-4 en with inverted polarity and delay 3, mid-frame reset with delay 2).
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Default 640x480 instance
  logic        rst_d, en_d;
  logic        d_hs, d_vs, d_vl, d_ls, d_fs;
  logic [9:0]  d_x, d_y, d_hc, d_vc;
  logic [15:0] d_fc;

  // Small mode H=8/1/2/1 (total 12), V=4/1/1/1 (total 7), FW=2
  logic        rst_s, en_s;
  logic        s_hs, s_vs, s_vl, s_ls, s_fs;
  logic [3:0]  s_x, s_y, s_hc, s_vc;
  logic [1:0]  s_fc;

  // Small mode, active-high syncs, DELAY=3, driven with 1-of-4 en
  logic        rst_q, en_q;
  logic        q_hs, q_vs, q_vl, q_ls, q_fs;
  logic [3:0]  q_x, q_y, q_hc, q_vc;
  logic [15:0] q_fc;

  // Small mode, DELAY=2, used for mid-frame reset
  logic        rst_r, en_r;
  logic        r_hs, r_vs, r_vl, r_ls, r_fs;
  logic [3:0]  r_x, r_y, r_hc, r_vc;
  logic [15:0] r_fc;

  vga_timing_gen u_def (
    .pclk(pclk), .reset(rst_d), .en(en_d),
    .hsync(d_hs), .vsync(d_vs), .valid(d_vl), .h_cnt(d_hc), .v_cnt(d_vc),
    .x_raw(d_x), .y_raw(d_y), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .CW(4), .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .FW(2)
  ) u_sm (
    .pclk(pclk), .reset(rst_s), .en(en_s),
    .hsync(s_hs), .vsync(s_vs), .valid(s_vl), .h_cnt(s_hc), .v_cnt(s_vc),
    .x_raw(s_x), .y_raw(s_y), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  vga_timing_gen #(
    .CW(4), .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1), .V_POL(1), .DELAY(3)
  ) u_q (
    .pclk(pclk), .reset(rst_q), .en(en_q),
    .hsync(q_hs), .vsync(q_vs), .valid(q_vl), .h_cnt(q_hc), .v_cnt(q_vc),
    .x_raw(q_x), .y_raw(q_y), .line_start(q_ls), .frame_start(q_fs), .frame_cnt(q_fc)
  );

  vga_timing_gen #(
    .CW(4), .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .DELAY(2)
  ) u_r (
    .pclk(pclk), .reset(rst_r), .en(en_r),
    .hsync(r_hs), .vsync(r_vs), .valid(r_vl), .h_cnt(r_hc), .v_cnt(r_vc),
    .x_raw(r_x), .y_raw(r_y), .line_start(r_ls), .frame_start(r_fs), .frame_cnt(r_fc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Expected small-mode outputs after t en-ticks since reset. Hand-derived windows:
  // active x 0..7, hsync x 9..10, active y 0..3, vsync y 5; 84 ticks per frame.
  task automatic chk_small(input string p, input int t, input int d, input bit hp, input bit vp,
                           input bit pulse_ok, input int fmod,
                           input logic [3:0] x, input logic [3:0] y,
                           input logic [3:0] hc, input logic [3:0] vc,
                           input logic hs, input logic vs, input logic vl,
                           input logic ls, input logic fs, input logic [31:0] fc);
    int ex, ey, sx, sy, s;
    bit act, ehs, evs, evl;
    ex  = t % 12;
    ey  = (t / 12) % 7;
    act = (ex < 8) && (ey < 4);
    if (t >= d) begin
      s   = t - d;
      sx  = s % 12;
      sy  = (s / 12) % 7;
      evl = (sx < 8) && (sy < 4);
      ehs = (sx == 9 || sx == 10) ? hp : !hp;
      evs = (sy == 5) ? vp : !vp;
    end else begin
      evl = 1'b0;
      ehs = !hp;
      evs = !vp;
    end
    chk({p, "_x"},     32'(x),  32'(ex));
    chk({p, "_y"},     32'(y),  32'(ey));
    chk({p, "_hcnt"},  32'(hc), act ? 32'(ex) : 32'd0);
    chk({p, "_vcnt"},  32'(vc), act ? 32'(ey) : 32'd0);
    chk({p, "_valid"}, 32'(vl), 32'(evl));
    chk({p, "_hsync"}, 32'(hs), 32'(ehs));
    chk({p, "_vsync"}, 32'(vs), 32'(evs));
    chk({p, "_lstart"}, 32'(ls), 32'(pulse_ok && t > 0 && ex == 0));
    chk({p, "_fstart"}, 32'(fs), 32'(pulse_ok && t > 0 && ex == 0 && ey == 0));
    chk({p, "_fcnt"},  fc, 32'((t / 84) % fmod));
  endtask

  initial begin
    int hs_first, hs_len, vl_len0, ls_cnt, vs_low, fs_cnt, t;
    bit prev_en;

    rst_d = 1'b1; rst_s = 1'b1; rst_q = 1'b1; rst_r = 1'b1;
    en_d  = 1'b1; en_s  = 1'b1; en_q  = 1'b1; en_r  = 1'b1;
    repeat (2) step();

    // Default mode: reset state then first two lines
    rst_d = 1'b0;
    chk("def_rst_x", 32'(d_x), 0);
    chk("def_rst_y", 32'(d_y), 0);
    chk("def_rst_fcnt", 32'(d_fc), 0);
    chk("def_rst_lstart", 32'(d_ls), 0);
    chk("def_rst_fstart", 32'(d_fs), 0);
    chk("def_rst_valid", 32'(d_vl), 1);
    chk("def_rst_hsync", 32'(d_hs), 1);
    chk("def_rst_vsync", 32'(d_vs), 1);
    hs_first = -1; hs_len = 0; vl_len0 = 0; ls_cnt = 0; vs_low = 0; fs_cnt = 0;
    for (int c = 0; c < 1700; c++) begin
      if (!d_hs) begin
        if (hs_first < 0) hs_first = int'(d_x);
        if (c < 800) hs_len++;
      end
      if (d_vl && c < 800) vl_len0++;
      if (d_ls) ls_cnt++;
      if (!d_vs) vs_low++;
      if (d_fs) fs_cnt++;
      if (c == 639) begin chk("def_valid_639", 32'(d_vl), 1); chk("def_hcnt_639", 32'(d_hc), 639); end
      if (c == 640) chk("def_valid_640", 32'(d_vl), 0);
      if (c == 655) chk("def_hsync_655", 32'(d_hs), 1);
      if (c == 656) chk("def_hsync_656", 32'(d_hs), 0);
      if (c == 700) chk("def_hcnt_700", 32'(d_hc), 0);
      if (c == 751) chk("def_hsync_751", 32'(d_hs), 0);
      if (c == 752) chk("def_hsync_752", 32'(d_hs), 1);
      if (c == 800) begin
        chk("def_lstart_800", 32'(d_ls), 1);
        chk("def_x_800", 32'(d_x), 0);
        chk("def_y_800", 32'(d_y), 1);
        chk("def_vcnt_800", 32'(d_vc), 1);
      end
      step();
    end
    chk("def_hs_first_x", 32'(hs_first), 656);
    chk("def_hs_len", 32'(hs_len), 96);
    chk("def_valid_len", 32'(vl_len0), 640);
    chk("def_lstart_count", 32'(ls_cnt), 2);
    chk("def_vsync_low", 32'(vs_low), 0);
    chk("def_fstart_count", 32'(fs_cnt), 0);
    rst_d = 1'b1;

    // Small mode, en tied high, four frames for the 2-bit frame counter wrap
    rst_s = 1'b0;
    for (int c = 0; c < 341; c++) begin
      chk_small("sm", c, 0, 1'b0, 1'b0, 1'b1, 4, s_x, s_y, s_hc, s_vc,
                s_hs, s_vs, s_vl, s_ls, s_fs, 32'(s_fc));
      step();
    end
    rst_s = 1'b1;

    // Small mode, 1-of-4 en, active-high syncs, DELAY=3; every pclk is checked
    en_q = 1'b0;
    rst_q = 1'b0;
    t = 0;
    prev_en = 1'b0;
    for (int k = 0; k < 700; k++) begin
      chk_small("q", t, 3, 1'b1, 1'b1, prev_en, 65536, q_x, q_y, q_hc, q_vc,
                q_hs, q_vs, q_vl, q_ls, q_fs, 32'(q_fc));
      en_q = (k % 4 == 3);
      step();
      if (en_q) t++;
      prev_en = en_q;
    end
    en_q = 1'b0;
    rst_q = 1'b1;

    // DELAY=2, reset asserted mid-frame at x=5, y=2 of the second frame
    rst_r = 1'b0;
    for (int c = 0; c < 113; c++) begin
      chk_small("r", c, 2, 1'b0, 1'b0, 1'b1, 65536, r_x, r_y, r_hc, r_vc,
                r_hs, r_vs, r_vl, r_ls, r_fs, 32'(r_fc));
      step();
    end
    chk("r_pre_x", 32'(r_x), 5);
    chk("r_pre_y", 32'(r_y), 2);
    chk("r_pre_fcnt", 32'(r_fc), 1);
    chk("r_pre_valid", 32'(r_vl), 1);
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    chk("r_post_x", 32'(r_x), 0);
    chk("r_post_y", 32'(r_y), 0);
    chk("r_post_fcnt", 32'(r_fc), 0);
    chk("r_post_valid", 32'(r_vl), 0);
    chk("r_post_hsync", 32'(r_hs), 1);
    chk("r_post_vsync", 32'(r_vs), 1);
    chk("r_post_lstart", 32'(r_ls), 0);
    chk("r_post_fstart", 32'(r_fs), 0);
    for (int c = 0; c < 100; c++) begin
      chk_small("r2", c, 2, 1'b0, 1'b0, 1'b1, 65536, r_x, r_y, r_hc, r_vc,
                r_hs, r_vs, r_vl, r_ls, r_fs, 32'(r_fc));
      step();
    end
    rst_r = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
